// File: rtl/vx_tma_engine.sv
// vx_tma_engine -- tensor-memory copy engine.
// Copies req_count words from system memory (byte address req_src_addr) into
// shared memory (word address req_dst_addr), NUM_LANES words per memory request.
// One command and one memory request are in flight at a time.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_*                           copy command from execute (valid/ready)
//   done_*                          completion with instruction tag (valid/ready)
//   core_req_*                      read request to system memory (valid/ready)
//   core_rsp_*                      read response from system memory (valid/ready)
//   smem_*                          shared-memory write port (we/ready)

// Per-lane request generation: byte address and active bit for lane LANE.
module vx_tma_lane #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_SIZE  = 4,
    parameter int LANE       = 0
) (
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [16:0]           idx_i,
    input  logic [15:0]           count_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  mask_o
);
    logic [17:0] widx;

    assign widx   = {1'b0, idx_i} + 18'(LANE);
    // Truncating the word index first keeps the product modulo 2^ADDR_WIDTH.
    assign addr_o = src_i + ADDR_WIDTH'(widx) * ADDR_WIDTH'(WORD_SIZE);
    assign mask_o = widx < {2'b00, count_i};
endmodule

module vx_tma_engine #(
    parameter int NUM_LANES       = 4,
    parameter int WORD_SIZE       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int SMEM_ADDR_WIDTH = 16,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [ADDR_WIDTH-1:0]                     req_src_addr,
    input  logic [SMEM_ADDR_WIDTH-1:0]                req_dst_addr,
    input  logic [15:0]                               req_count,
    input  logic [TAG_WIDTH-1:0]                      req_tag,
    output logic                                      done_valid,
    input  logic                                      done_ready,
    output logic [TAG_WIDTH-1:0]                      done_tag,
    output logic                                      core_req_valid,
    input  logic                                      core_req_ready,
    output logic                                      core_req_rw,
    output logic [NUM_LANES-1:0]                      core_req_mask,
    output logic [NUM_LANES-1:0][WORD_SIZE-1:0]       core_req_byteen,
    output logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]      core_req_addr,
    output logic [NUM_LANES-1:0][WORD_SIZE*8-1:0]     core_req_data,
    output logic [TAG_WIDTH-1:0]                      core_req_tag,
    input  logic                                      core_rsp_valid,
    output logic                                      core_rsp_ready,
    input  logic [NUM_LANES-1:0]                      core_rsp_mask,
    input  logic [NUM_LANES-1:0][WORD_SIZE*8-1:0]     core_rsp_data,
    input  logic [TAG_WIDTH-1:0]                      core_rsp_tag,
    output logic                                      smem_we,
    input  logic                                      smem_ready,
    output logic [SMEM_ADDR_WIDTH-1:0]                smem_addr,
    output logic [WORD_SIZE*8-1:0]                    smem_wdata
);
    localparam int DW = WORD_SIZE * 8;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {IDLE, REQ, RSP, WR, DONE} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           src_q, src_d;
    logic [SMEM_ADDR_WIDTH-1:0]      dst_q, dst_d;
    logic [15:0]                     count_q, count_d;
    logic [TAG_WIDTH-1:0]            tag_q, tag_d;
    // 17 bits so idx can reach 65535+lanes without wrapping back below count.
    logic [16:0]                     idx_q, idx_d;
    logic [NUM_LANES-1:0][DW-1:0]    data_q, data_d;
    logic [NUM_LANES-1:0]            mask_q, mask_d;
    logic [LW-1:0]                   lane_q, lane_d;

    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
    logic [NUM_LANES-1:0]                 lane_mask;
    logic                                 more;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vx_tma_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WORD_SIZE  (WORD_SIZE),
            .LANE       (g)
        ) u_lane (
            .src_i   (src_q),
            .idx_i   (idx_q),
            .count_i (count_q),
            .addr_o  (lane_addr[g]),
            .mask_o  (lane_mask[g])
        );
    end

    // Any captured lane above the current one still to be written?
    always_comb begin
        more = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_q[i] && (i > int'(lane_q))) more = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        lane_d  = lane_q;

        req_ready       = 1'b0;
        done_valid      = 1'b0;
        done_tag        = '0;
        core_req_valid  = 1'b0;
        core_req_rw     = 1'b0;
        core_req_mask   = '0;
        core_req_byteen = '0;
        core_req_addr   = '0;
        core_req_data   = '0;
        core_req_tag    = '0;
        core_rsp_ready  = 1'b0;
        smem_we         = 1'b0;
        smem_addr       = '0;
        smem_wdata      = '0;

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so all outputs read 0.
                req_ready = ~reset;
                if (req_valid && !reset) begin
                    src_d   = req_src_addr;
                    dst_d   = req_dst_addr;
                    count_d = req_count;
                    tag_d   = req_tag;
                    idx_d   = '0;
                    state_d = (req_count == 16'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                core_req_valid  = 1'b1;
                core_req_byteen = '1;
                core_req_addr   = lane_addr;
                core_req_mask   = lane_mask;
                core_req_tag    = tag_q;
                if (core_req_ready) state_d = RSP;
            end
            RSP: begin
                core_rsp_ready = 1'b1;
                // Stale-tag responses are accepted and discarded.
                if (core_rsp_valid && core_rsp_tag == tag_q) begin
                    data_d  = core_rsp_data;
                    mask_d  = core_rsp_mask;
                    lane_d  = '0;
                    state_d = WR;
                end
            end
            WR: begin
                if (mask_q[lane_q]) begin
                    smem_we    = 1'b1;
                    smem_addr  = dst_q + SMEM_ADDR_WIDTH'(idx_q);
                    smem_wdata = data_q[lane_q];
                    if (smem_ready) begin
                        idx_d  = idx_q + 17'd1;
                        lane_d = lane_q + LW'(1);
                        if (!more)
                            state_d = ((idx_q + 17'd1) == {1'b0, count_q}) ? DONE : REQ;
                    end
                end else begin
                    // Unmasked lane: skip without writing.
                    lane_d = lane_q + LW'(1);
                    if (!more)
                        state_d = (idx_q == {1'b0, count_q}) ? DONE : REQ;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                done_tag   = tag_q;
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vx_tma_engine.sv
module tb_vx_tma_engine;
    localparam int NL  = 4;
    localparam int WS  = 4;
    localparam int AW  = 32;
    localparam int SAW = 16;
    localparam int TW  = 8;
    localparam int DW  = WS * 8;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic [AW-1:0]             req_src_addr = '0;
    logic [SAW-1:0]            req_dst_addr = '0;
    logic [15:0]               req_count = '0;
    logic [TW-1:0]             req_tag = '0;
    logic                      done_valid;
    logic                      done_ready = 1'b0;
    logic [TW-1:0]             done_tag;
    logic                      core_req_valid;
    logic                      core_req_ready;
    logic                      core_req_rw;
    logic [NL-1:0]             core_req_mask;
    logic [NL-1:0][WS-1:0]     core_req_byteen;
    logic [NL-1:0][AW-1:0]     core_req_addr;
    logic [NL-1:0][DW-1:0]     core_req_data;
    logic [TW-1:0]             core_req_tag;
    logic                      core_rsp_valid;
    logic                      core_rsp_ready;
    logic [NL-1:0]             core_rsp_mask;
    logic [NL-1:0][DW-1:0]     core_rsp_data;
    logic [TW-1:0]             core_rsp_tag;
    logic                      smem_we;
    logic                      smem_ready;
    logic [SAW-1:0]            smem_addr;
    logic [DW-1:0]             smem_wdata;

    vx_tma_engine dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_src_addr(req_src_addr),
        .req_dst_addr(req_dst_addr), .req_count(req_count), .req_tag(req_tag),
        .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_rw(core_req_rw),
        .core_req_mask(core_req_mask), .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
        .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready), .core_rsp_mask(core_rsp_mask),
        .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
        .smem_we(smem_we), .smem_ready(smem_ready), .smem_addr(smem_addr), .smem_wdata(smem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0][AW-1:0] addr;
        logic [NL-1:0]         mask;
        logic [TW-1:0]         tag;
        logic                  rw;
        logic [NL-1:0][WS-1:0] byteen;
        logic [NL-1:0][DW-1:0] data;
    } req_t;
    typedef struct packed {
        logic [TW-1:0]         tag;
        logic [NL-1:0]         mask;
        logic [NL-1:0][DW-1:0] data;
    } rsp_t;
    typedef struct packed {
        logic [SAW-1:0] addr;
        logic [DW-1:0]  data;
    } wr_t;

    req_t req_log[$];
    wr_t  wr_log[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int stall_left = 0;
    int stall_seen = 0;
    int unstable = 0;
    int rsp_fired = 0;
    int smem_mode = 0;
    int done_seen = 0;
    bit inject_wrong = 1'b0;

    // System memory contents: a fixed hash of the byte address.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // System memory: accepts requests (with optional stall), answers each
    // with one response, optionally preceded by a stale-tag response.
    initial begin : mem_model
        req_t cur, snap;
        rsp_t r;
        bit   have_snap;
        have_snap      = 1'b0;
        core_req_ready = 1'b0;
        core_rsp_valid = 1'b0;
        core_rsp_mask  = '0;
        core_rsp_data  = '0;
        core_rsp_tag   = '0;
        forever begin
            @(negedge clk);
            core_rsp_valid = 1'b0;
            core_req_ready = 1'b0;
            if (reset) begin
                rsp_q.delete();
                have_snap = 1'b0;
                continue;
            end
            if (rsp_q.size() > 0 && core_rsp_ready) begin
                r = rsp_q.pop_front();
                core_rsp_valid = 1'b1;
                core_rsp_tag   = r.tag;
                core_rsp_mask  = r.mask;
                core_rsp_data  = r.data;
                rsp_fired++;
            end
            if (core_req_valid) begin
                cur = '{core_req_addr, core_req_mask, core_req_tag, core_req_rw,
                        core_req_byteen, core_req_data};
                if (have_snap && cur != snap) unstable++;
                if (stall_left > 0) begin
                    snap = cur;
                    have_snap = 1'b1;
                    stall_left--;
                    stall_seen++;
                end else begin
                    have_snap = 1'b0;
                    core_req_ready = 1'b1;
                    req_log.push_back(cur);
                    r.mask = cur.mask;
                    for (int i = 0; i < NL; i++) r.data[i] = memf(cur.addr[i]);
                    if (inject_wrong) begin
                        r.tag = cur.tag ^ 8'h01;
                        r.data = ~r.data;
                        rsp_q.push_back(r);
                        for (int i = 0; i < NL; i++) r.data[i] = memf(cur.addr[i]);
                        inject_wrong = 1'b0;
                    end
                    r.tag = cur.tag;
                    rsp_q.push_back(r);
                end
            end
        end
    end

    // Shared memory sink: mode 0 always ready, 1 toggling, 2 random.
    initial begin : smem_model
        wr_t w;
        smem_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (smem_mode)
                0:       smem_ready = 1'b1;
                1:       smem_ready = ~smem_ready;
                default: smem_ready = 1'($urandom_range(0, 1));
            endcase
            if (!reset && smem_we && smem_ready) begin
                w.addr = smem_addr;
                w.data = smem_wdata;
                wr_log.push_back(w);
            end
            if (done_valid) done_seen++;
        end
    end

    task automatic send_cmd(input logic [AW-1:0] s, input logic [SAW-1:0] d,
                            input logic [15:0] c, input logic [TW-1:0] t);
        int k = 0;
        while (!req_ready && k < 200) begin @(negedge clk); k++; end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
            return;
        end
        req_valid = 1'b1; req_src_addr = s; req_dst_addr = d; req_count = c; req_tag = t;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [AW-1:0] s, input logic [SAW-1:0] d,
                           input logic [15:0] c, input logic [TW-1:0] t, input string nm);
        int k, nreq;
        logic [NL-1:0][AW-1:0] ea;
        logic [NL-1:0]         em;
        logic [SAW-1:0]        wa;
        logic [DW-1:0]         wd;
        req_log.delete();
        wr_log.delete();
        send_cmd(s, d, c, t);
        k = 0;
        while (!done_valid && k < 3000) begin @(negedge clk); k++; end
        n_cmp++;
        if (done_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done_valid=%b required 1", nm, done_valid);
        end else begin
            n_cmp++;
            if (done_tag !== t) begin
                n_fail++;
                $display("FAIL %s done_tag: got %0h required %0h", nm, done_tag, t);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                n_cmp++;
                if (done_valid !== 1'b1 || done_tag !== t) begin
                    n_fail++;
                    $display("FAIL %s done_hold: valid=%b tag=%0h required 1/%0h", nm, done_valid, done_tag, t);
                end
            end
            done_ready = 1'b1;
            @(negedge clk);
            done_ready = 1'b0;
            n_cmp++;
            if (done_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_drop: done_valid=%b required 0", nm, done_valid);
            end
        end
        nreq = (int'(c) + NL - 1) / NL;
        n_cmp++;
        if (req_log.size() != nreq) begin
            n_fail++;
            $display("FAIL %s req_count: got %0d required %0d", nm, req_log.size(), nreq);
        end
        for (int q = 0; q < nreq && q < req_log.size(); q++) begin
            for (int i = 0; i < NL; i++) begin
                ea[i] = s + AW'((q * NL + i) * WS);
                em[i] = (q * NL + i) < int'(c);
            end
            n_cmp++;
            if (req_log[q].addr !== ea || req_log[q].mask !== em || req_log[q].tag !== t ||
                req_log[q].rw !== 1'b0 || req_log[q].byteen !== '1 || req_log[q].data !== '0) begin
                n_fail++;
                $display("FAIL %s req%0d: addr=%h mask=%b tag=%h rw=%b required addr=%h mask=%b tag=%h rw=0",
                         nm, q, req_log[q].addr, req_log[q].mask, req_log[q].tag, req_log[q].rw, ea, em, t);
            end
        end
        n_cmp++;
        if (wr_log.size() != int'(c)) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", nm, wr_log.size(), c);
        end
        for (int j = 0; j < int'(c) && j < wr_log.size(); j++) begin
            wa = d + SAW'(j);
            wd = memf(s + AW'(j * WS));
            n_cmp++;
            if (wr_log[j].addr !== wa || wr_log[j].data !== wd) begin
                n_fail++;
                $display("FAIL %s write%0d: addr=%h data=%h required addr=%h data=%h",
                         nm, j, wr_log[j].addr, wr_log[j].data, wa, wd);
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        n_cmp++;
        if ({req_ready, done_valid, done_tag, core_req_valid, core_req_rw, core_req_mask,
             core_req_byteen, core_req_addr, core_req_data, core_req_tag, core_rsp_ready,
             smem_we, smem_addr, smem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not all 0 (req_ready=%b done_valid=%b core_req_valid=%b rsp_ready=%b smem_we=%b) required all 0",
                     nm, req_ready, done_valid, core_req_valid, core_rsp_ready, smem_we);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1 check_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || core_req_valid !== 1'b0 || done_valid !== 1'b0 ||
            smem_we !== 1'b0 || core_rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b creq=%b done=%b we=%b rsp_rdy=%b required 1/0/0/0/0",
                     req_ready, core_req_valid, done_valid, smem_we, core_rsp_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        req_log.delete();
        wr_log.delete();
        send_cmd(32'h0000_2000, 16'h0010, 16'd0, 8'h12);
        n_cmp++;
        if (done_valid !== 1'b1 || done_tag !== 8'h12) begin
            n_fail++;
            $display("FAIL zero_done_latency: valid=%b tag=%h required 1/12", done_valid, done_tag);
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        n_cmp++;
        if (req_log.size() != 0 || wr_log.size() != 0 || done_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_activity: reqs=%0d writes=%0d done=%b required 0/0/0",
                     req_log.size(), wr_log.size(), done_valid);
        end
    endtask

    task automatic test_basic();
        smem_mode = 0;
        run_cmd(32'h0000_1000, 16'h0020, 16'd6, 8'h5A, "basic");
    endtask

    task automatic test_req_stall();
        smem_mode = 0;
        stall_seen = 0;
        unstable = 0;
        stall_left = 5;
        run_cmd(32'h0000_4400, 16'h0100, 16'd4, 8'h33, "stall");
        n_cmp++;
        if (stall_seen != 5 || unstable != 0) begin
            n_fail++;
            $display("FAIL stall_stable: stalled=%0d changes=%0d required 5/0", stall_seen, unstable);
        end
    endtask

    task automatic test_smem_toggle();
        smem_mode = 1;
        run_cmd(32'h0000_8000, 16'h0040, 16'd7, 8'h71, "smem_toggle");
        smem_mode = 0;
    endtask

    task automatic test_wrong_tag();
        smem_mode = 0;
        rsp_fired = 0;
        inject_wrong = 1'b1;
        run_cmd(32'h0000_0C00, 16'h0300, 16'd3, 8'hA4, "wrong_tag");
        n_cmp++;
        if (rsp_fired != 2) begin
            n_fail++;
            $display("FAIL wrong_tag_consumed: responses=%0d required 2", rsp_fired);
        end
    endtask

    task automatic test_wrap();
        smem_mode = 2;
        run_cmd(32'hFFFF_FFF8, 16'hFFFE, 16'd5, 8'hC1, "wrap");
        smem_mode = 0;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int d0;
        smem_mode = 0;
        req_log.delete();
        wr_log.delete();
        send_cmd(32'h0000_3000, 16'h0050, 16'd4, 8'h44);
        while (wr_log.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
        n_cmp++;
        if (wr_log.size() != 2 || smem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: writes=%0d we=%b required 2/1", wr_log.size(), smem_we);
        end
        d0 = done_seen;
        reset = 1'b1;
        #1 check_all_zero("reset_mid_outputs");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || core_rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: req_ready=%b rsp_ready=%b required 1/0", req_ready, core_rsp_ready);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_seen != d0 || wr_log.size() != 2) begin
            n_fail++;
            $display("FAIL reset_mid_abandon: done_cycles=%0d writes=%0d required %0d/2",
                     done_seen, wr_log.size(), d0);
        end
        run_cmd(32'h0000_5000, 16'h0060, 16'd4, 8'h45, "after_reset");
    endtask

    task automatic test_random();
        logic [AW-1:0]  s;
        logic [SAW-1:0] d;
        logic [15:0]    c;
        logic [TW-1:0]  t;
        for (int n = 0; n < 8; n++) begin
            s = $urandom() & 32'hFFFF_FFFC;
            d = SAW'($urandom());
            c = 16'($urandom_range(0, 13));
            t = TW'($urandom());
            stall_left = $urandom_range(0, 3);
            smem_mode = $urandom_range(0, 2);
            run_cmd(s, d, c, t, "random");
        end
        stall_left = 0;
        smem_mode = 0;
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_basic();
        test_req_stall();
        test_smem_toggle();
        test_wrong_tag();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vx_tma_engine.md
VX_TMA_ENGINE -- requirements
Module: VX_tma_engine

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, the number of word lanes per memory request.
REQ-002 SHALL have parameter WORD_SIZE, default 4, the bytes per word.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, the system byte-address width.
REQ-004 SHALL have parameter SMEM_ADDR_WIDTH, default 16, the shared-memory word-address width.
REQ-005 SHALL have parameter TAG_WIDTH, default 8, the instruction and memory tag width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req_valid / req_ready, input / output, 1 bit each: the copy-command handshake from execute.
REQ-009 SHALL have port req_src_addr, input, ADDR_WIDTH: the word-aligned system byte address.
REQ-010 SHALL have ports req_dst_addr, input, SMEM_ADDR_WIDTH, the shared-memory word address, and req_count, input, 16 bits, the word count.
REQ-011 SHALL have port req_tag, input, TAG_WIDTH: the instruction tag.
REQ-012 SHALL have ports done_valid, output, 1 bit; done_ready, input, 1 bit; done_tag, output, TAG_WIDTH: the completion handshake.
REQ-013 SHALL have ports core_req_valid, output, 1 bit; core_req_ready, input, 1 bit; core_req_rw, output, 1 bit; core_req_mask, output, NUM_LANES: the memory request handshake and controls.
REQ-014 SHALL have ports core_req_byteen, output, NUM_LANES x WORD_SIZE; core_req_addr, output, NUM_LANES x ADDR_WIDTH; core_req_data, output, NUM_LANES x WORD_SIZE*8; core_req_tag, output, TAG_WIDTH.
REQ-015 SHALL have ports core_rsp_valid, input, 1 bit; core_rsp_ready, output, 1 bit; core_rsp_mask, input, NUM_LANES; core_rsp_data, input, NUM_LANES x WORD_SIZE*8; core_rsp_tag, input, TAG_WIDTH.
REQ-016 SHALL have ports smem_we, output, 1 bit; smem_ready, input, 1 bit; smem_addr, output, SMEM_ADDR_WIDTH; smem_wdata, output, WORD_SIZE*8: the shared-memory write port.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, RSP, WR and DONE, with one command in flight and one outstanding memory request at a time.
REQ-018 SHALL assert req_ready only in IDLE; on req fire SHALL latch src, dst, count and tag, clear the word index, and go to DONE if count==0, otherwise to REQ.
REQ-019 SHALL, in REQ, assert core_req_valid with rw=0, all byteen ones, data=0 and core_req_tag=latched tag.
REQ-020 SHALL drive lane i of a request with addr=src+(idx+i)*WORD_SIZE (modulo 2^ADDR_WIDTH) and mask[i]=(idx+i<count).
REQ-021 SHALL hold all request outputs stable until core_req_ready, then go to RSP.
REQ-022 SHALL, in RSP, assert core_rsp_ready; a response with tag≠latched tag SHALL be consumed and dropped; a matching response SHALL capture data and mask and move to WR.
REQ-023 SHALL, in WR, walk the captured lanes in ascending order, writing only masked lanes.
REQ-024 SHALL drive each write with smem_we=1, smem_addr=dst+idx (wrapping at 2^SMEM_ADDR_WIDTH) and smem_wdata=lane data, advancing idx only on smem_ready.
REQ-025 SHALL, after the last masked lane of a chunk, go to DONE if idx==count, otherwise to REQ.
REQ-026 SHALL, in DONE, assert done_valid with done_tag, holding both until done_ready, then return to IDLE.
REQ-027 SHALL issue ceil(count/NUM_LANES) requests for count≥1; the final partial chunk carries a partial mask.
REQ-028 SHALL write zero words and complete with count==0, with done_valid one cycle after the req fire.
REQ-029 SHALL keep idx at 17 bits so that count=65535 terminates without overflow.
REQ-030 SHALL deassert all valid, ready and we outputs outside their owning state.

Reset
REQ-031 SHALL, on asynchronous reset assertion, enter IDLE immediately and clear idx, the latched fields and the captured data.
REQ-032 SHALL hold every output at 0 during reset, except req_ready, which SHALL be 1 after reset release.
REQ-033 SHALL, on reset mid-operation, abandon the command with no done pulse; a response arriving later in IDLE SHALL see core_rsp_ready=0.

Verification
REQ-034 Bench SHALL cover: count=0, tag=0x12 -> zero requests, zero smem writes, done_valid with tag 0x12 one cycle after fire.
REQ-035 Bench SHALL cover: src=0x1000, dst=0x20, count=6, NUM_LANES=4 -> requests with addr 0x1000..0x100C mask 1111, then 0x1010..0x101C mask 0011; six writes to 0x20..0x25 in order; then done.
REQ-036 Bench SHALL cover: core_req_ready held low 5 cycles -> request outputs unchanged throughout; exactly one request fires.
REQ-037 Bench SHALL cover: smem_ready toggling 0/1 -> each word written exactly once, in order, with no skips.
REQ-038 Bench SHALL cover: a response with the wrong tag followed by the right tag -> the first is consumed with no write, the second is written.
REQ-039 Bench SHALL cover: reset asserted in WR after 2 of 4 writes -> outputs go to 0 immediately, no done; a new command after reset completes normally.
